fp_mul_round: RTL

FP_MUL_ROUND -- requirements
Module: fp_mul_round

---
 rtl/fpu_pkg.sv | 36 +++
 rtl/fp_round_rne.sv | 32 +++
 rtl/fp_mul_round.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: special-operand classes, flag bit positions,
// canonical quiet NaN, exponent bias and the normalize-stage payload.
package fpu_pkg;

    typedef enum logic [1:0] {
        SP_NORMAL = 2'd0,
        SP_ZERO   = 2'd1,
        SP_INF    = 2'd2,
        SP_NAN    = 2'd3
    } special_e;

    // Bit positions inside a {NV,DZ,OF,UF,NX} flag vector
    localparam int FLAG_NV = 4;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_OF = 2;
    localparam int FLAG_UF = 1;
    localparam int FLAG_NX = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int          BIAS = 127;

    // Biased exponent at or above this value no longer fits a finite single
    localparam logic signed [9:0] EXP_INF = 10'(2 * BIAS + 1);

    // Normalized operand held between normalize and round/pack
    typedef struct packed {
        logic        sign;
        special_e    special;
        logic        invalid;
        logic [23:0] sig;
        logic        guard;
        logic        sticky;
        logic [9:0]  exp;
    } s1_t;

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a 24-bit significand with guard/sticky, fixing up
// the exponent on carry-out and on a denormal promoted to the smallest normal.
module fp_round_rne (
    input  logic              [23:0] sig_i,
    input  logic                     guard_i,
    input  logic                     sticky_i,
    input  logic signed       [9:0]  exp_i,
    output logic              [23:0] sig_o,
    output logic signed       [9:0]  exp_o,
    output logic                     inexact_o
);

    logic        inc;
    logic [24:0] sum;

    assign inc       = guard_i & (sticky_i | sig_i[0]);
    assign sum       = {1'b0, sig_i} + {24'd0, inc};
    assign inexact_o = guard_i | sticky_i;

    // Renormalize on carry; a denormal that reaches the hidden bit becomes exponent 1
    always_comb begin
        sig_o = sum[23:0];
        exp_o = exp_i;
        if (sum[24]) begin
            sig_o = sum[24:1];
            exp_o = exp_i + 10'sd1;
        end else if (exp_i == 10'sd0 && sum[23]) begin
            exp_o = 10'sd1;
        end
    end

endmodule

// File: rtl/fp_mul_round.sv
// Back end of a single-precision multiplier: normalizes the raw significand
// product (S1), then rounds and packs the IEEE result with exception flags (S2).
module fp_mul_round
    import fpu_pkg::*;
#(
    parameter int LATENCY = 2  // only 2 is supported
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sign,
    input  logic signed [9:0]  in_exp_sum,
    input  logic        [47:0] in_mant_prod,
    input  logic        [1:0]  in_special,
    input  logic               in_invalid,
    output logic               out_valid,
    input  logic               out_ready,
    output logic        [31:0] out_result,
    output logic        [4:0]  out_flags,
    output logic        [4:0]  fflags,
    input  logic               fflags_clear
);

    // vld_q[0] = normalize stage, vld_q[LATENCY-1] = output stage
    logic [LATENCY-1:0] vld_q;
    s1_t                s1_q, s1_d;
    logic [31:0]        res_q, res_d;
    logic [4:0]         flg_q, flg_d;
    logic [4:0]         ff_q, ff_d;
    logic               s2_ready;

    assign s2_ready = !vld_q[LATENCY-1] || out_ready;
    assign in_ready = !vld_q[0] || s2_ready;

    // ---------------- S1: normalize ----------------
    logic signed [9:0] e_n;
    logic [23:0]       sig_n;
    logic              g_n, st_n;
    logic [4:0]        sh;
    logic [50:0]       ext;

    // Align product to a 24-bit significand, then shift denormals down into guard/sticky
    always_comb begin
        if (in_mant_prod[47]) begin
            e_n   = in_exp_sum + 10'sd1;
            sig_n = in_mant_prod[47:24];
            g_n   = in_mant_prod[23];
            st_n  = |in_mant_prod[22:0];
        end else begin
            e_n   = in_exp_sum;
            sig_n = in_mant_prod[46:23];
            g_n   = in_mant_prod[22];
            st_n  = |in_mant_prod[21:0];
        end
        // Beyond 26 every significand bit already lands in sticky
        sh = 5'd0;
        if (e_n <= 10'sd0)
            sh = (e_n < -10'sd25) ? 5'd26 : 5'(10'sd1 - e_n);
        ext = {sig_n, g_n, 26'd0} >> sh;

        s1_d.sign    = in_sign;
        s1_d.special = special_e'(in_special);
        s1_d.invalid = in_invalid;
        s1_d.sig     = ext[50:27];
        s1_d.guard   = ext[26];
        s1_d.sticky  = st_n | (|ext[25:0]);
        s1_d.exp     = (e_n <= 10'sd0) ? 10'd0 : e_n;
    end

    // ---------------- S2: round / pack ----------------
    logic [23:0]       r_sig;
    logic signed [9:0] r_exp;
    logic              r_nx;

    fp_round_rne u_rne (
        .sig_i    (s1_q.sig),
        .guard_i  (s1_q.guard),
        .sticky_i (s1_q.sticky),
        .exp_i    ($signed(s1_q.exp)),
        .sig_o    (r_sig),
        .exp_o    (r_exp),
        .inexact_o(r_nx)
    );

    // Pack result; specials bypass rounding, overflow saturates to infinity
    always_comb begin
        res_d = {s1_q.sign, r_exp[7:0], r_sig[22:0]};
        flg_d = 5'd0;
        case (s1_q.special)
            SP_ZERO: res_d = {s1_q.sign, 31'd0};
            SP_INF:  res_d = {s1_q.sign, 8'hFF, 23'd0};
            SP_NAN: begin
                res_d          = QNAN;
                flg_d[FLAG_NV] = s1_q.invalid;
            end
            default: begin
                flg_d[FLAG_NX] = r_nx;
                if (r_exp >= EXP_INF) begin
                    res_d          = {s1_q.sign, 8'hFF, 23'd0};
                    flg_d[FLAG_OF] = 1'b1;
                    flg_d[FLAG_NX] = 1'b1;
                end else begin
                    // No hidden bit after rounding means denormal or zero
                    flg_d[FLAG_UF] = r_nx && !r_sig[23];
                end
            end
        endcase
    end

    // Clear drops history, but the flags of a same-cycle handshake still stick
    always_comb begin
        ff_d = (fflags_clear ? 5'd0 : ff_q) | ((vld_q[LATENCY-1] && out_ready) ? flg_q : 5'd0);
    end

    // Pipeline registers: each stage loads only when its successor can take it
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            vld_q <= '0;
            s1_q  <= '0;
            res_q <= '0;
            flg_q <= '0;
            ff_q  <= '0;
        end else begin
            if (in_ready) begin
                vld_q[0] <= in_valid;
                if (in_valid)
                    s1_q <= s1_d;
            end
            if (s2_ready) begin
                vld_q[LATENCY-1] <= vld_q[0];
                if (vld_q[0]) begin
                    res_q <= res_d;
                    flg_q <= flg_d;
                end
            end
            ff_q <= ff_d;
        end
    end

    assign out_valid  = vld_q[LATENCY-1];
    assign out_result = res_q;
    assign out_flags  = flg_q;
    assign fflags     = ff_q;

endmodule
